// File: rtl/forward_ctrl.sv
// Hazard controller for the five-stage pipeline: tracks destination metadata of
// in-flight instructions, drives EX operand-forwarding selects and load-use stalls.
module forward_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0]       SEL_RF  = 2'b00;
    localparam logic [1:0]       SEL_WB  = 2'b01;
    localparam logic [1:0]       SEL_MEM = 2'b10;
    localparam logic [REG_W-1:0] REG_X0  = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A stage produces register r only if it is real, writes, and r is not x0.
    function automatic logic f_writes(
        input logic             valid,
        input logic             regwrite,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] r
    );
        return valid && regwrite && (rd == r) && (r != REG_X0);
    endfunction

    // EX/MEM holds the newer value, so it wins over MEM/WB.
    function automatic logic [1:0] f_select(
        input logic mem_hit,
        input logic wb_hit
    );
        logic [1:0] sel;
        if (mem_hit) begin
            sel = SEL_MEM;
        end else if (wb_hit) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    logic             r_idex_valid;
    logic [REG_W-1:0] r_idex_rd;
    logic [REG_W-1:0] r_idex_rs1;
    logic [REG_W-1:0] r_idex_rs2;
    logic             r_idex_regwrite;
    logic             r_idex_memread;

    // Downstream stages only feed forwarding; load detection looks at ID/EX alone.
    logic             r_exmem_valid;
    logic [REG_W-1:0] r_exmem_rd;
    logic             r_exmem_regwrite;

    logic             r_memwb_valid;
    logic [REG_W-1:0] r_memwb_rd;
    logic             r_memwb_regwrite;

    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_stall;
    logic             w_bubble;
    logic             w_load_in_ex;
    logic             w_rs_match;
    logic             w_a_mem_hit;
    logic             w_a_wb_hit;
    logic             w_b_mem_hit;
    logic             w_b_wb_hit;

    assign w_load_in_ex = r_idex_valid && r_idex_memread && (r_idex_rd != REG_X0);
    assign w_rs_match   = (r_idex_rd == id_rs1_i) || (r_idex_rd == id_rs2_i);
    assign w_stall      = w_load_in_ex && id_valid_i && w_rs_match;
    assign w_bubble     = w_stall || flush_i;

    assign w_a_mem_hit = f_writes(r_exmem_valid, r_exmem_regwrite, r_exmem_rd, r_idex_rs1);
    assign w_a_wb_hit  = f_writes(r_memwb_valid, r_memwb_regwrite, r_memwb_rd, r_idex_rs1);
    assign w_b_mem_hit = f_writes(r_exmem_valid, r_exmem_regwrite, r_exmem_rd, r_idex_rs2);
    assign w_b_wb_hit  = f_writes(r_memwb_valid, r_memwb_regwrite, r_memwb_rd, r_idex_rs2);

    // Operand-mux selects for the instruction currently in EX.
    always_comb begin
        fwd_a_o = SEL_RF;
        fwd_b_o = SEL_RF;
        fwd_a_o = f_select(w_a_mem_hit, w_a_wb_hit);
        fwd_b_o = f_select(w_b_mem_hit, w_b_wb_hit);
    end

    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

    // ID/EX shadow: takes the ID instruction, or a bubble on stall/flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idex_valid    <= 1'b0;
            r_idex_regwrite <= 1'b0;
            r_idex_memread  <= 1'b0;
            r_idex_rd       <= REG_X0;
            r_idex_rs1      <= REG_X0;
            r_idex_rs2      <= REG_X0;
        end else if (w_bubble) begin
            r_idex_valid    <= 1'b0;
            r_idex_regwrite <= 1'b0;
            r_idex_memread  <= 1'b0;
            r_idex_rd       <= REG_X0;
            r_idex_rs1      <= REG_X0;
            r_idex_rs2      <= REG_X0;
        end else begin
            r_idex_valid    <= id_valid_i;
            r_idex_regwrite <= id_regwrite_i;
            r_idex_memread  <= id_memread_i;
            r_idex_rd       <= id_rd_i;
            r_idex_rs1      <= id_rs1_i;
            r_idex_rs2      <= id_rs2_i;
        end
    end

    // EX/MEM and MEM/WB shadows advance every cycle, stall or not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_exmem_valid    <= 1'b0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_rd       <= REG_X0;
            r_memwb_valid    <= 1'b0;
            r_memwb_regwrite <= 1'b0;
            r_memwb_rd       <= REG_X0;
        end else begin
            r_exmem_valid    <= r_idex_valid;
            r_exmem_regwrite <= r_idex_regwrite;
            r_exmem_rd       <= r_idex_rd;
            r_memwb_valid    <= r_exmem_valid;
            r_memwb_regwrite <= r_exmem_regwrite;
            r_memwb_rd       <= r_exmem_rd;
        end
    end

    // Saturating stall-cycle counter for performance monitoring.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed hazard scenarios plus randomized
// traffic against a history-based model of what entered EX in recent cycles.
module tb_forward_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CNT_SAT = 15;

    logic             clk;
    logic             rst_i;
    logic             id_valid_i;
    logic [REG_W-1:0] id_rs1_i;
    logic [REG_W-1:0] id_rs2_i;
    logic [REG_W-1:0] id_rd_i;
    logic             id_regwrite_i;
    logic             id_memread_i;
    logic             flush_i;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int checks = 0;
    int failures = 0;

    forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       rw;
        bit       mr;
    } ins_t;

    // hist[2] = instruction in EX, hist[1] = one cycle older, hist[0] = two older.
    ins_t hist[$];
    ins_t bub;
    int   mcnt;

    function automatic bit m_writes(input ins_t x, input bit [4:0] r);
        return x.v && x.rw && (x.rd == r) && (r != 5'd0);
    endfunction

    function automatic bit [1:0] m_sel(input bit [4:0] r);
        if (m_writes(hist[1], r)) return 2'b10;
        if (m_writes(hist[0], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        ins_t e;
        e = hist[2];
        return e.v && e.mr && (e.rd != 5'd0) && id_valid_i &&
               ((e.rd == id_rs1_i) || (e.rd == id_rs2_i));
    endfunction

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit rw, input bit mr, input bit fl);
        id_valid_i    = v;
        id_rs1_i      = rs1[4:0];
        id_rs2_i      = rs2[4:0];
        id_rd_i       = rd[4:0];
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        bit   st;
        bit   fl;
        ins_t e;
        st    = m_stall();
        fl    = flush_i;
        e.v   = id_valid_i;
        e.rd  = id_rd_i;
        e.rs1 = id_rs1_i;
        e.rs2 = id_rs2_i;
        e.rw  = id_regwrite_i;
        e.mr  = id_memread_i;
        @(posedge clk);
        if (rst_i) begin
            hist.delete();
            repeat (3) hist.push_back(bub);
            mcnt = 0;
        end else begin
            if (st && mcnt < CNT_SAT) mcnt++;
            if (st || fl) hist.push_back(bub);
            else          hist.push_back(e);
            void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        rst_i = 1'b0;
        idle();
        checks++; if (fwd_a_o !== 2'b00) begin failures++; $display("FAIL reset_fwd_a got=%b exp=00", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin failures++; $display("FAIL reset_fwd_b got=%b exp=00", fwd_b_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 0, 0, 4, 1'b1, 1'b1, 1'b0);         // lw x4
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lu_pre_stall got=%b exp=0", stall_o); end
        tick();
        drive(1'b1, 4, 4, 3, 1'b1, 1'b0, 1'b0);         // add x3,x4,x4
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL lu_cnt0 got=%0d exp=0", stall_cnt_o); end
        tick();
        drive(1'b1, 4, 4, 3, 1'b1, 1'b0, 1'b0);         // add held in ID
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lu_stall_once got=%b exp=0", stall_o); end
        checks++; if (stall_cnt_o !== 4'd1) begin failures++; $display("FAIL lu_cnt1 got=%0d exp=1", stall_cnt_o); end
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin failures++; $display("FAIL lu_bubble_sel got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
        tick();
        idle();
        checks++; if (fwd_a_o !== 2'b01) begin failures++; $display("FAIL lu_fwd_a got=%b exp=01", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b01) begin failures++; $display("FAIL lu_fwd_b got=%b exp=01", fwd_b_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b0);         // add x5
        tick();
        drive(1'b1, 5, 7, 6, 1'b1, 1'b0, 1'b0);         // sub x6,x5,x7
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b exp=0", stall_o); end
        tick();
        idle();
        checks++; if (fwd_a_o !== 2'b10) begin failures++; $display("FAIL b2b_fwd_a got=%b exp=10", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin failures++; $display("FAIL b2b_fwd_b got=%b exp=00", fwd_b_o); end
        tick();
    endtask

    task automatic test_distance_two();
        drive(1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b0);         // add x5
        tick();
        drive(1'b1, 1, 2, 9, 1'b1, 1'b0, 1'b0);         // unrelated
        tick();
        drive(1'b1, 7, 5, 8, 1'b1, 1'b0, 1'b0);         // or x8,x7,x5
        tick();
        idle();
        checks++; if (fwd_b_o !== 2'b01) begin failures++; $display("FAIL dist2_fwd_b got=%b exp=01", fwd_b_o); end
        checks++; if (fwd_a_o !== 2'b00) begin failures++; $display("FAIL dist2_fwd_a got=%b exp=00", fwd_a_o); end
        tick();
    endtask

    task automatic test_double_hazard();
        drive(1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3, 4, 5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5, 5, 9, 1'b1, 1'b0, 1'b0);         // and x9,x5,x5
        tick();
        idle();
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b1010) begin failures++; $display("FAIL double_sel got=%b exp=1010", {fwd_a_o, fwd_b_o}); end
        tick();
    endtask

    task automatic test_x0_flush();
        drive(1'b1, 1, 0, 0, 1'b1, 1'b0, 1'b0);         // addi x0
        tick();
        drive(1'b1, 0, 0, 1, 1'b1, 1'b0, 1'b0);         // add x1,x0,x0
        tick();
        idle();
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin failures++; $display("FAIL x0_sel got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
        tick();
        drive(1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b1);         // add x5, flushed
        tick();
        drive(1'b1, 1, 2, 9, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5, 5, 7, 1'b1, 1'b0, 1'b0);         // consumer of x5
        tick();
        idle();
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin failures++; $display("FAIL flush_sel got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
        tick();
    endtask

    task automatic test_random();
        bit es;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0));
            es = m_stall();
            checks++; if (stall_o !== es) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall_o, es); end
            checks++; if (fwd_a_o !== m_sel(hist[2].rs1)) begin failures++; $display("FAIL rnd_fwd_a cyc=%0d got=%b exp=%b", i, fwd_a_o, m_sel(hist[2].rs1)); end
            checks++; if (fwd_b_o !== m_sel(hist[2].rs2)) begin failures++; $display("FAIL rnd_fwd_b cyc=%0d got=%b exp=%b", i, fwd_b_o, m_sel(hist[2].rs2)); end
            checks++; if (int'(stall_cnt_o) != mcnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt_o, mcnt); end
            tick();
        end
        repeat (3) begin idle(); tick(); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 0, 0, 4, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 4, 4, 3, 1'b1, 1'b0, 1'b0);
            checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL sat_stall it=%0d got=%b exp=1", i, stall_o); end
            tick();
            drive(1'b1, 4, 4, 3, 1'b1, 1'b0, 1'b0);
            checks++; if (int'(stall_cnt_o) != mcnt) begin failures++; $display("FAIL sat_cnt it=%0d got=%0d exp=%0d", i, stall_cnt_o, mcnt); end
            tick();
        end
        idle();
        checks++; if (stall_cnt_o !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 0, 0, 4, 1'b1, 1'b1, 1'b0);         // lw x4
        tick();
        drive(1'b1, 0, 0, 5, 1'b1, 1'b1, 1'b0);         // lw x5
        tick();
        rst_i = 1'b1;
        drive(1'b1, 4, 5, 6, 1'b1, 1'b0, 1'b0);
        tick();
        rst_i = 1'b0;
        drive(1'b1, 4, 5, 6, 1'b1, 1'b0, 1'b0);
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", stall_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", stall_cnt_o); end
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin failures++; $display("FAIL rstmid_sel0 got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
        tick();
        idle();
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin failures++; $display("FAIL rstmid_sel1 got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
        tick();
    endtask

    initial begin
        bub = '{v: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, rw: 1'b0, mr: 1'b0};
        repeat (3) hist.push_back(bub);
        mcnt = 0;
        rst_i = 1'b1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_distance_two();
        test_double_hazard();
        test_x0_flush();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Pipeline hazard controller for the five-stage CPU. Tracks destination-register metadata of in-flight instructions through internal ID/EX, EX/MEM and MEM/WB shadow registers. Drives the 2-bit select inputs of the two EX-stage operand forwarding muxes (ALU operand A and B). Detects load-use hazards, requests a one-cycle stall, and keeps a saturating count of stall cycles for performance monitoring.

## Interface
- `REG_W`, 5, register-index width
- `CNT_W`, 16, stall-counter width
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `id_valid_i`  in  1  instruction in ID is real (not a bubble)
- `id_rs1_i`  in  REG_W  ID source register 1
- `id_rs2_i`  in  REG_W  ID source register 2
- `id_rd_i`  in  REG_W  ID destination register
- `id_regwrite_i`  in  1  ID instruction writes the register file
- `id_memread_i`  in  1  ID instruction is a load
- `flush_i`  in  1  branch taken; squash the ID instruction
- `fwd_a_o`  out  2  operand-A select for the EX instruction
- `fwd_b_o`  out  2  operand-B select for the EX instruction
- `stall_o`  out  1  load-use stall: hold PC and IF/ID
- `stall_cnt_o`  out  CNT_W  total stall cycles since reset, saturating

## Operation
- Select encoding is fixed by the operand muxes:
  - 00: register file
  - 01: MEM/WB result (load data or ALU result being written back)
  - 10: EX/MEM ALU result
  - 11: never driven
- Internal stages, each holding valid, rd, regwrite and memread; ID/EX also holds rs1 and rs2:
  - ID/EX: loads the ID fields each cycle.
  - EX/MEM: loads from ID/EX each cycle.
  - MEM/WB: loads from EX/MEM each cycle.
- A stage "writes r" when valid=1, regwrite=1, rd=r and r≠0.
- Forward A, evaluated on the ID/EX rs1:
  - If EX/MEM writes rs1, drive 10.
  - Otherwise, if MEM/WB writes rs1, drive 01.
  - Otherwise, drive 00.
- Forward B: same rule on the ID/EX rs2.
- EX/MEM has priority over MEM/WB because it holds the newer value.
- Register 0 is never forwarded, so a match on rd=0 gives 00.
- stall_o is asserted when all of the following hold:
  - ID/EX valid=1, memread=1, rd≠0;
  - id_valid_i=1;
  - rd equals id_rs1_i or id_rs2_i.
- When stall_o or flush_i is asserted, ID/EX loads a bubble (valid=0, regwrite=0, memread=0; other fields don't-care) instead of the ID fields.
  - EX/MEM and MEM/WB still advance.
- flush_i together with stall_o: a bubble is inserted and the stall is counted.
- stall_cnt_o increments by 1 each cycle stall_o=1. It holds at 2^CNT_W−1 and does not wrap.
- A load in EX/MEM with a matching consumer in EX is not a legal state, because the stall prevents it. If it does occur, the forward rules still select 10.

## Timing
- fwd_a_o, fwd_b_o: combinational from registered state only. They are valid in the same cycle the instruction occupies EX.
- stall_o: combinational from ID/EX state and the current ID inputs. The stall lasts exactly one cycle per load-use pair: after the bubble, the load is in EX/MEM with memread set, and the stall rule only checks ID/EX.
- Consumer of a load, after the 1-cycle stall, gets 01 from MEM/WB.
- Reset (rst_i=1 at a rising edge):
  - All stage valid/regwrite/memread bits go to 0 and stall_cnt_o goes to 0.
  - From the next cycle: fwd_a_o=00, fwd_b_o=00, stall_o=0.
- Reset mid-pipeline discards all in-flight metadata. No forward may be produced from pre-reset instructions.
- rst_i has priority over flush_i and stall.

## Test plan
- ALU back-to-back. Stimulus: `add x5` (regwrite), then `sub x6,x5,x7` next cycle. Required: when sub is in EX, fwd_a_o=10, fwd_b_o=00, stall_o never asserted.
- Distance two. Stimulus: `add x5`, an unrelated instruction, then `or x8,x7,x5`. Required: fwd_b_o=01 when `or` is in EX.
- Double hazard. Stimulus: `add x5`, `add x5`, then `and x9,x5,x5`. Required: fwd_a_o=fwd_b_o=10, i.e. the newer value wins.
- Load-use. Stimulus: `lw x4` then `add x3,x4,x4`. Required:
  - stall_o=1 for exactly 1 cycle and stall_cnt_o goes 0→1;
  - a bubble appears in EX;
  - then fwd_a_o=fwd_b_o=01 for the `add`.
- x0 and flush. Stimulus: `addi x0`, then `add x1,x0,x0`. Required: selects 00.
  - Also: flush_i on an ID `add x5`, then a consumer of x5 two cycles later. Required: selects 00.
- Saturation and reset. Stimulus: force 2^CNT_W+3 load-use stalls (CNT_W=4 build: 19 stalls). Required: stall_cnt_o holds at 15.
  - Then assert rst_i for 1 cycle with loads in flight. Required: stall_cnt_o=0, all selects 00, stall_o=0.
